// File: rtl/demux8_pkg.sv
// Shared constants and state type for the 8:1 strobed-mux scanning deserializer.
package demux8_pkg;

    localparam int unsigned LANES = 8;
    localparam int unsigned SEL_W = 3;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StHold
    } state_e;

endpackage

// File: rtl/demux8_lane_ctr.sv
// Settle counter and lane select counter: holds each lane for SETTLE+1 cycles and
// flags the cycle on which the current lane is to be sampled.
module demux8_lane_ctr
    import demux8_pkg::*;
#(
    parameter int unsigned SETTLE = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             enable_i,
    output logic [SEL_W-1:0] sel_o,
    output logic             sample_o,
    output logic             last_lane_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             settled;
    logic             last_lane;

    assign settled   = (cnt_q == CNT_W'(SETTLE));
    assign last_lane = (sel_q == SEL_W'(LANES - 1));

    always_comb begin
        cnt_d = cnt_q;
        sel_d = sel_q;
        if (clear_i) begin
            cnt_d = '0;
            sel_d = '0;
        end else if (enable_i) begin
            if (!settled) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else begin
                cnt_d = '0;
                // After the last lane the select returns to 0 rather than counting on.
                sel_d = last_lane ? '0 : sel_q + SEL_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            sel_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            sel_q <= sel_d;
        end
    end

    assign sel_o       = sel_q;
    assign sample_o    = enable_i && settled;
    assign last_lane_o = last_lane;

endmodule

// File: rtl/demux8_scan.sv
// Scanning deserializer: walks the mux select, samples true/complement per lane,
// and offers the assembled word with an error flag on a valid/ready handshake.
module demux8_scan
    import demux8_pkg::*;
#(
    parameter int unsigned SETTLE = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    output logic [SEL_W-1:0] sel_o,
    output logic             strobe_n_o,
    input  logic             din_i,
    input  logic             din_n_i,
    output logic [LANES-1:0] word_o,
    output logic             word_valid_o,
    input  logic             word_ready_i,
    output logic             err_o,
    output logic             busy_o
);

    state_e           state_q, state_d;
    logic [LANES-1:0] word_q, word_d;
    logic             err_q, err_d;
    logic             valid_q, valid_d;
    logic             strobe_n_q, strobe_n_d;
    logic             busy_q, busy_d;

    logic             ctr_clear;
    logic             ctr_enable;
    logic [SEL_W-1:0] sel;
    logic             sample;
    logic             last_lane;

    demux8_lane_ctr #(
        .SETTLE(SETTLE)
    ) u_lane_ctr (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (ctr_clear),
        .enable_i    (ctr_enable),
        .sel_o       (sel),
        .sample_o    (sample),
        .last_lane_o (last_lane)
    );

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        err_d      = err_q;
        valid_d    = valid_q;
        strobe_n_d = strobe_n_q;
        busy_d     = busy_q;
        ctr_clear  = 1'b0;
        ctr_enable = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    ctr_clear  = 1'b1;
                    state_d    = StScan;
                    strobe_n_d = 1'b0;
                    err_d      = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            StScan: begin
                ctr_enable = 1'b1;
                if (sample) begin
                    word_d[sel] = din_i;
                    err_d       = err_q | (din_i == din_n_i);
                    if (last_lane) begin
                        state_d    = StHold;
                        strobe_n_d = 1'b1;
                        valid_d    = 1'b1;
                    end
                end
            end
            StHold: begin
                if (valid_q && word_ready_i) begin
                    valid_d = 1'b0;
                    if (start_i) begin
                        // Restart on the handshake edge; busy stays high.
                        ctr_clear  = 1'b1;
                        state_d    = StScan;
                        strobe_n_d = 1'b0;
                        err_d      = 1'b0;
                    end else begin
                        state_d = StIdle;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            word_q     <= '0;
            err_q      <= 1'b0;
            valid_q    <= 1'b0;
            strobe_n_q <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            err_q      <= err_d;
            valid_q    <= valid_d;
            strobe_n_q <= strobe_n_d;
            busy_q     <= busy_d;
        end
    end

    assign sel_o        = sel;
    assign strobe_n_o   = strobe_n_q;
    assign word_o       = word_q;
    assign word_valid_o = valid_q;
    assign err_o        = err_q;
    assign busy_o       = busy_q;

    a_hold_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == StHold && !word_ready_i) |=> ($stable(word_q) && $stable(err_q) && valid_q));

    a_strobe_scan: assert property (@(posedge clk_i) disable iff (!rst_ni)
        strobe_n_q == (state_q != StScan));

    a_busy_state: assert property (@(posedge clk_i) disable iff (!rst_ni)
        busy_q == (state_q != StIdle));

endmodule

// File: tb/tb_demux8_scan.sv
// Self-checking bench for demux8_scan with a behavioural model of the 8:1 strobed mux.
module tb_demux8_scan;

    localparam int unsigned SETTLE = 1;
    localparam int          LAT    = 8 * (SETTLE + 1);

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [2:0] sel;
    logic       strobe_n;
    logic       din;
    logic       din_n;
    logic [7:0] word;
    logic       word_valid;
    logic       word_ready;
    logic       err;
    logic       busy;

    logic [7:0] data;
    int         err_lane;

    int pass_cnt  = 0;
    int total_cnt = 0;

    demux8_scan #(
        .SETTLE(SETTLE)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .sel_o        (sel),
        .strobe_n_o   (strobe_n),
        .din_i        (din),
        .din_n_i      (din_n),
        .word_o       (word),
        .word_valid_o (word_valid),
        .word_ready_i (word_ready),
        .err_o        (err),
        .busy_o       (busy)
    );

    // Mux model; err_lane forces the complement to equal the true output on one lane.
    assign din   = !strobe_n ? data[sel] : 1'b0;
    assign din_n = (!strobe_n && err_lane == int'(sel)) ? din : ~din;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        int         elane;
        logic [7:0] exp_word;
        logic       exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, " sel"}, 32'(sel), 32'd0);
        chk({tag, " strobe_n"}, 32'(strobe_n), 32'd1);
        chk({tag, " word"}, 32'(word), 32'h00);
        chk({tag, " valid"}, 32'(word_valid), 32'd0);
        chk({tag, " err"}, 32'(err), 32'd0);
        chk({tag, " busy"}, 32'(busy), 32'd0);
    endtask

    // Called at the negedge in IDLE; returns at the negedge right after the start edge.
    task automatic start_pulse();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called one half-cycle after the start edge; returns at the negedge after word_valid rises.
    task automatic track_scan(input logic [7:0] exp_w, input logic exp_e, input string tag);
        for (int k = 0; k < LAT; k++) begin
            chk({tag, " sel"}, 32'(sel), 32'(k / (SETTLE + 1)));
            chk({tag, " strobe_n low"}, 32'(strobe_n), 32'd0);
            chk({tag, " valid low"}, 32'(word_valid), 32'd0);
            @(negedge clk);
        end
        chk({tag, " valid"}, 32'(word_valid), 32'd1);
        chk({tag, " word"}, 32'(word), 32'(exp_w));
        chk({tag, " err"}, 32'(err), 32'(exp_e));
        chk({tag, " strobe_n high"}, 32'(strobe_n), 32'd1);
        chk({tag, " sel back to 0"}, 32'(sel), 32'd0);
    endtask

    task automatic accept(input int delay, input logic [7:0] exp_w, input logic exp_e,
                          input string tag);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            chk({tag, " held valid"}, 32'(word_valid), 32'd1);
            chk({tag, " held word"}, 32'(word), 32'(exp_w));
            chk({tag, " held err"}, 32'(err), 32'(exp_e));
        end
        word_ready = 1'b1;
        @(negedge clk);
        word_ready = 1'b0;
        chk({tag, " valid dropped"}, 32'(word_valid), 32'd0);
        chk({tag, " idle"}, 32'(busy), 32'd0);
    endtask

    vec_t vecs[6];

    initial begin
        logic [7:0] rd;
        int         rl;
        int         guard;

        rst_n      = 1'b0;
        start      = 1'b0;
        word_ready = 1'b0;
        data       = 8'h00;
        err_lane   = -1;

        #12;
        chk_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic scan followed by backpressure with a start pulse during HOLD.
        data = 8'hA5;
        start_pulse();
        track_scan(8'hA5, 1'b0, "basic");
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            @(negedge clk);
            start = 1'b0;
            chk("bp valid", 32'(word_valid), 32'd1);
            chk("bp word", 32'(word), 32'hA5);
            chk("bp err", 32'(err), 32'd0);
            chk("bp strobe_n", 32'(strobe_n), 32'd1);
            chk("bp sel", 32'(sel), 32'd0);
        end
        accept(0, 8'hA5, 1'b0, "bp");

        // Back-to-back: restart on the handshake edge.
        data = 8'h12;
        start_pulse();
        track_scan(8'h12, 1'b0, "b2b first");
        data       = 8'h3C;
        word_ready = 1'b1;
        start      = 1'b1;
        @(negedge clk);
        word_ready = 1'b0;
        start      = 1'b0;
        chk("b2b valid dropped", 32'(word_valid), 32'd0);
        chk("b2b strobe_n", 32'(strobe_n), 32'd0);
        chk("b2b busy", 32'(busy), 32'd1);
        track_scan(8'h3C, 1'b0, "b2b second");
        accept(1, 8'h3C, 1'b0, "b2b");

        // Error flag on lane 5, then a clean scan clears it.
        data     = 8'hFF;
        err_lane = 5;
        start_pulse();
        track_scan(8'hFF, 1'b1, "err");
        err_lane = -1;
        accept(0, 8'hFF, 1'b1, "err");
        start_pulse();
        track_scan(8'hFF, 1'b0, "clean");
        accept(0, 8'hFF, 1'b0, "clean");

        // Asynchronous reset mid-scan at lane 3.
        data = 8'h5A;
        start_pulse();
        guard = 0;
        while (sel != 3'd3 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        chk("reach lane 3", 32'(sel), 32'd3);
        #2 rst_n = 1'b0;
        #1 chk_reset_values("async reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        data = 8'h81;
        start_pulse();
        track_scan(8'h81, 1'b0, "after reset");
        accept(0, 8'h81, 1'b0, "after reset");

        // Table of patterns.
        vecs[0] = '{8'h00, -1, 8'h00, 1'b0};
        vecs[1] = '{8'hFF, -1, 8'hFF, 1'b0};
        vecs[2] = '{8'h01, 0, 8'h01, 1'b1};
        vecs[3] = '{8'h80, 7, 8'h80, 1'b1};
        vecs[4] = '{8'h6D, -1, 8'h6D, 1'b0};
        vecs[5] = '{8'h92, 3, 8'h92, 1'b1};
        for (int v = 0; v < 6; v++) begin
            data     = vecs[v].d;
            err_lane = vecs[v].elane;
            start_pulse();
            track_scan(vecs[v].exp_word, vecs[v].exp_err, $sformatf("vec%0d", v));
            err_lane = -1;
            accept(v % 3, vecs[v].exp_word, vecs[v].exp_err, $sformatf("vec%0d", v));
        end

        // Randomized scans against the model: word equals the lane data, err iff a lane was forced.
        for (int r = 0; r < 20; r++) begin
            rd       = 8'($urandom);
            rl       = int'($urandom_range(0, 11));
            data     = rd;
            err_lane = (rl <= 7) ? rl : -1;
            start_pulse();
            track_scan(rd, (rl <= 7), $sformatf("rnd%0d", r));
            err_lane = -1;
            accept(int'($urandom_range(0, 3)), rd, (rl <= 7), $sformatf("rnd%0d", r));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
